// File: rtl/ahb_error_satellite_if.sv
// AHB-Lite slave-side bus bundle shared by the error satellite and its bus mux.
// The satellite only ever answers, so it sees the address-phase signals as inputs.
interface ahb_bus_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              hsel;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic              hready;
  logic [DATA_W-1:0] hrdata;
  logic              hreadyout;
  logic              hresp;

  modport satellite_to_mux (
    input  hsel,
    input  haddr,
    input  htrans,
    input  hwrite,
    input  hready,
    output hrdata,
    output hreadyout,
    output hresp
  );

  modport mux_to_satellite (
    output hsel,
    output haddr,
    output htrans,
    output hwrite,
    output hready,
    input  hrdata,
    input  hreadyout,
    input  hresp
  );
endinterface

// File: rtl/ahb_error_satellite.sv
// AHB-Lite default slave: answers every real transfer with a two-cycle ERROR after optional waits.
// Fault logging (sticky first address, saturating count) exists only with AHB_ERROR_SAT_FAULT_LOG_EN.
module ahb_error_satellite #(
  parameter int ADDR_W      = 32,
  parameter int WAIT_STATES = 0,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  ahb_bus_if.satellite_to_mux   abif,
  input  logic                  fault_clear,
  output logic                  fault_valid,
  output logic [ADDR_W-1:0]     fault_addr,
  output logic                  fault_write,
  output logic [CNT_W-1:0]      fault_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR1 = 2'd2,
    ERR2 = 2'd3
  } state_t;

  // Counter is preloaded with WAIT_STATES-1 so WAIT lasts exactly WAIT_STATES cycles.
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam state_t     LAUNCH    = (WAIT_STATES > 0) ? WAIT : ERR1;

  state_t     state_reg;
  state_t     state_next;
  logic [3:0] wait_cnt_reg;
  logic [3:0] wait_cnt_next;
  logic       accept;

  // Only IDLE and ERR2 can take a new address phase; hready is low bus-wide otherwise.
  assign accept = abif.hsel && abif.hready && abif.htrans[1] &&
                  ((state_reg == IDLE) || (state_reg == ERR2));

  assign abif.hrdata = '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= 4'd0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    wait_cnt_next  = wait_cnt_reg;
    abif.hreadyout = 1'b1;
    abif.hresp     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next    = LAUNCH;
          wait_cnt_next = WAIT_INIT;
        end
      end
      WAIT: begin
        abif.hreadyout = 1'b0;
        if (wait_cnt_reg == 4'd0) begin
          state_next = ERR1;
        end else begin
          wait_cnt_next = wait_cnt_reg - 4'd1;
        end
      end
      ERR1: begin
        abif.hreadyout = 1'b0;
        abif.hresp     = 1'b1;
        state_next     = ERR2;
      end
      ERR2: begin
        abif.hresp = 1'b1;
        // A fault issued during the final ERROR cycle starts immediately, with no OKAY gap.
        if (accept) begin
          state_next    = LAUNCH;
          wait_cnt_next = WAIT_INIT;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next    = IDLE;
        wait_cnt_next = 4'd0;
      end
    endcase
  end

`ifdef AHB_ERROR_SAT_FAULT_LOG_EN
  logic              fault_valid_reg;
  logic [ADDR_W-1:0] fault_addr_reg;
  logic              fault_write_reg;
  logic [CNT_W-1:0]  fault_count_reg;
  logic              capture;
  logic              unused;

  // A clear in the same cycle as a new fault lets the new fault replace the record.
  assign capture = accept && (!fault_valid_reg || fault_clear);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_valid_reg <= 1'b0;
      fault_addr_reg  <= '0;
      fault_write_reg <= 1'b0;
      fault_count_reg <= '0;
    end else begin
      if (accept) begin
        fault_valid_reg <= 1'b1;
      end else if (fault_clear) begin
        fault_valid_reg <= 1'b0;
      end
      if (capture) begin
        fault_addr_reg  <= abif.haddr[ADDR_W-1:0];
        fault_write_reg <= abif.hwrite;
      end
      if (accept && (fault_count_reg != {CNT_W{1'b1}})) begin
        fault_count_reg <= fault_count_reg + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign fault_valid = fault_valid_reg;
  assign fault_addr  = fault_addr_reg;
  assign fault_write = fault_write_reg;
  assign fault_count = fault_count_reg;
  assign unused      = abif.htrans[0];
`else
  logic unused;

  assign fault_valid = 1'b0;
  assign fault_addr  = '0;
  assign fault_write = 1'b0;
  assign fault_count = '0;
  assign unused      = ^{fault_clear, abif.haddr, abif.hwrite, abif.htrans[0]};
`endif

endmodule

// File: tb/tb_ahb_error_satellite.sv
// Directed bench for ahb_error_satellite: three instances (0 waits, 3 waits, 2-bit counter).
// Fault-record expectations collapse to zero when AHB_ERROR_SAT_FAULT_LOG_EN is undefined.
module tb_ahb_error_satellite;

`ifdef AHB_ERROR_SAT_FAULT_LOG_EN
  localparam bit LOG = 1'b1;
`else
  localparam bit LOG = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ahb_bus_if #(.ADDR_W(32), .DATA_W(32)) b0 ();
  ahb_bus_if #(.ADDR_W(32), .DATA_W(32)) b3 ();
  ahb_bus_if #(.ADDR_W(32), .DATA_W(32)) bc ();

  // Single slave on each bus: hready follows its own hreadyout.
  assign b0.hready = b0.hreadyout;
  assign b3.hready = b3.hreadyout;
  assign bc.hready = bc.hreadyout;

  logic        fc0, fc3, fcc;
  logic        fv0, fv3, fvc;
  logic [31:0] fa0, fa3, fac;
  logic        fw0, fw3, fwc;
  logic [15:0] cnt0, cnt3;
  logic [1:0]  cntc;

  ahb_error_satellite #(.ADDR_W(32), .WAIT_STATES(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .abif(b0), .fault_clear(fc0),
    .fault_valid(fv0), .fault_addr(fa0), .fault_write(fw0), .fault_count(cnt0)
  );

  ahb_error_satellite #(.ADDR_W(32), .WAIT_STATES(3), .CNT_W(16)) dut3 (
    .clk(clk), .rst(rst), .abif(b3), .fault_clear(fc3),
    .fault_valid(fv3), .fault_addr(fa3), .fault_write(fw3), .fault_count(cnt3)
  );

  ahb_error_satellite #(.ADDR_W(32), .WAIT_STATES(0), .CNT_W(2)) dutc (
    .clk(clk), .rst(rst), .abif(bc), .fault_clear(fcc),
    .fault_valid(fvc), .fault_addr(fac), .fault_write(fwc), .fault_count(cntc)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [63:0] fx(input logic [63:0] v);
    return LOG ? v : 64'd0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    fc0 = 1'b0; fc3 = 1'b0; fcc = 1'b0;
    b0.hsel = 1'b0; b0.haddr = '0; b0.htrans = 2'b00; b0.hwrite = 1'b0;
    b3.hsel = 1'b0; b3.haddr = '0; b3.htrans = 2'b00; b3.hwrite = 1'b0;
    bc.hsel = 1'b0; bc.haddr = '0; bc.htrans = 2'b00; bc.hwrite = 1'b0;

    // Reset state
    step();
    chk("rst_hreadyout0", b0.hreadyout, 1);
    chk("rst_hresp0",     b0.hresp, 0);
    chk("rst_hrdata0",    b0.hrdata, 0);
    chk("rst_fv0",        fv0, 0);
    chk("rst_fa0",        fa0, 0);
    chk("rst_cnt0",       cnt0, 0);
    chk("rst_hreadyout3", b3.hreadyout, 1);
    chk("rst_cntc",       cntc, 0);
    step();
    rst = 1'b0;
    step();
    chk("idle_okay0", {b0.hreadyout, b0.hresp}, 2'b10);

    // Zero-wait read fault at 0x4000_0010
    $display("txn A: dut0 NONSEQ read 0x40000010");
    b0.hsel = 1'b1; b0.htrans = 2'b10; b0.haddr = 32'h4000_0010; b0.hwrite = 1'b0;
    step();
    b0.hsel = 1'b0; b0.htrans = 2'b00;
    chk("A_err1", {b0.hreadyout, b0.hresp}, 2'b01);
    chk("A_fv",   fv0, fx(1));
    chk("A_fa",   fa0, fx(32'h4000_0010));
    chk("A_fw",   fw0, 0);
    chk("A_cnt",  cnt0, fx(1));
    step();
    chk("A_err2", {b0.hreadyout, b0.hresp}, 2'b11);
    chk("A_hrdata", b0.hrdata, 0);
    step();
    chk("A_okay", {b0.hreadyout, b0.hresp}, 2'b10);

    // IDLE and BUSY with hsel get OKAY and are not counted
    $display("txn A2: dut0 IDLE then BUSY with hsel");
    b0.hsel = 1'b1; b0.htrans = 2'b00; b0.haddr = 32'h99;
    step();
    chk("A2_idle_okay", {b0.hreadyout, b0.hresp}, 2'b10);
    b0.htrans = 2'b01;
    step();
    chk("A2_busy_okay", {b0.hreadyout, b0.hresp}, 2'b10);
    chk("A2_cnt", cnt0, fx(1));
    chk("A2_fa",  fa0, fx(32'h4000_0010));
    b0.hsel = 1'b0; b0.htrans = 2'b00;

    // Clear only drops fault_valid
    $display("txn A3: dut0 fault_clear pulse");
    fc0 = 1'b1;
    step();
    fc0 = 1'b0;
    chk("A3_fv",  fv0, 0);
    chk("A3_fa",  fa0, fx(32'h4000_0010));
    chk("A3_cnt", cnt0, fx(1));

    // Three-wait write fault
    $display("txn B: dut3 NONSEQ write 0x20");
    b3.hsel = 1'b1; b3.htrans = 2'b10; b3.haddr = 32'h20; b3.hwrite = 1'b1;
    step();
    b3.hsel = 1'b0; b3.htrans = 2'b00; b3.hwrite = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("B_wait%0d", i), {b3.hreadyout, b3.hresp}, 2'b00);
      step();
    end
    chk("B_err1", {b3.hreadyout, b3.hresp}, 2'b01);
    step();
    chk("B_err2", {b3.hreadyout, b3.hresp}, 2'b11);
    chk("B_fw",   fw3, fx(1));
    chk("B_fa",   fa3, fx(32'h20));
    chk("B_cnt",  cnt3, fx(1));
    step();
    chk("B_okay", {b3.hreadyout, b3.hresp}, 2'b10);

    // Back-to-back: second fault issued in ERR2 of the first
    $display("txn C: dutc NONSEQ 0x4 then 0x8 during ERR2");
    bc.hsel = 1'b1; bc.htrans = 2'b10; bc.haddr = 32'h4; bc.hwrite = 1'b0;
    step();
    bc.hsel = 1'b0; bc.htrans = 2'b00;
    chk("C_err1a", {bc.hreadyout, bc.hresp}, 2'b01);
    chk("C_cnt1",  cntc, fx(1));
    step();
    chk("C_err2a", {bc.hreadyout, bc.hresp}, 2'b11);
    bc.hsel = 1'b1; bc.htrans = 2'b10; bc.haddr = 32'h8; bc.hwrite = 1'b1;
    step();
    bc.hsel = 1'b0; bc.htrans = 2'b00; bc.hwrite = 1'b0;
    chk("C_err1b", {bc.hreadyout, bc.hresp}, 2'b01);
    chk("C_fa",    fac, fx(32'h4));
    chk("C_fw",    fwc, 0);
    chk("C_cnt2",  cntc, fx(2));
    step();
    chk("C_err2b", {bc.hreadyout, bc.hresp}, 2'b11);
    step();
    chk("C_okay",  {bc.hreadyout, bc.hresp}, 2'b10);

    // Clear and new fault in the same cycle: new fault wins
    $display("txn D: dutc fault_clear with NONSEQ write 0xC");
    fcc = 1'b1;
    bc.hsel = 1'b1; bc.htrans = 2'b10; bc.haddr = 32'hC; bc.hwrite = 1'b1;
    step();
    fcc = 1'b0;
    bc.hsel = 1'b0; bc.htrans = 2'b00; bc.hwrite = 1'b0;
    chk("D_fv",  fvc, fx(1));
    chk("D_fa",  fac, fx(32'hC));
    chk("D_fw",  fwc, fx(1));
    chk("D_cnt3", cntc, fx(3));
    step();
    step();

    // Saturation of the 2-bit counter
    $display("txn E: dutc faults 4 and 5 saturate counter");
    bc.hsel = 1'b1; bc.htrans = 2'b10; bc.haddr = 32'h10;
    step();
    bc.hsel = 1'b0; bc.htrans = 2'b00;
    chk("E_cnt4", cntc, fx(3));
    step();
    bc.hsel = 1'b1; bc.htrans = 2'b11; bc.haddr = 32'h14;
    step();
    bc.hsel = 1'b0; bc.htrans = 2'b00;
    chk("E_err1_seq", {bc.hreadyout, bc.hresp}, 2'b01);
    chk("E_cnt5", cntc, fx(3));
    chk("E_fa",   fac, fx(32'hC));
    step();
    step();

    // Asynchronous reset in ERR1
    $display("txn F: dut0 fault at 0x50, reset during ERR1");
    b0.hsel = 1'b1; b0.htrans = 2'b10; b0.haddr = 32'h50;
    step();
    b0.hsel = 1'b0; b0.htrans = 2'b00;
    chk("F_err1", {b0.hreadyout, b0.hresp}, 2'b01);
    chk("F_cnt",  cnt0, fx(2));
    #2;
    rst = 1'b1;
    #1;
    chk("F_rst_resp", {b0.hreadyout, b0.hresp}, 2'b10);
    chk("F_rst_fv",   fv0, 0);
    chk("F_rst_fa",   fa0, 0);
    chk("F_rst_fw",   fw0, 0);
    chk("F_rst_cnt",  cnt0, 0);
    chk("F_rst_cntc", cntc, 0);
    step();
    rst = 1'b0;
    b0.hsel = 1'b1; b0.htrans = 2'b00; b0.haddr = 32'h60;
    step();
    chk("F_idle_okay", {b0.hreadyout, b0.hresp}, 2'b10);
    step();
    chk("F_idle_okay2", {b0.hreadyout, b0.hresp}, 2'b10);
    chk("F_cnt_after", cnt0, 0);
    b0.hsel = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
